// File: rtl/writeback_sequencer_pkg.sv
// rtl/writeback_sequencer_pkg.sv - shared op-class, state and rd source-select types
package JZJCoreFTypes;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_ALU    = 3'd1,
        OP_LOAD   = 3'd2,
        OP_IMM    = 3'd3,
        OP_JUMP   = 3'd4,
        OP_STORE  = 3'd5,
        OP_BRANCH = 3'd6
    } OpClass_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EXEC      = 2'd1,
        LOAD_WAIT = 2'd2,
        WB        = 2'd3
    } StateWB_t;

    typedef struct packed {
        logic memory;
        logic alu;
        logic immediateFormer;
        logic branchALU;
    } RDSourceSelectLines_t;

    localparam RDSourceSelectLines_t SEL_NONE   = 4'b0000;
    localparam RDSourceSelectLines_t SEL_MEMORY = 4'b1000;
    localparam RDSourceSelectLines_t SEL_ALU    = 4'b0100;
    localparam RDSourceSelectLines_t SEL_IMM    = 4'b0010;
    localparam RDSourceSelectLines_t SEL_BRALU  = 4'b0001;

    // Unused encoding (3'd7) collapses to OP_NONE so it retires without side effects.
    function automatic OpClass_t decode_op(input logic [2:0] raw);
        OpClass_t op;
        case (raw)
            3'd1:    op = OP_ALU;
            3'd2:    op = OP_LOAD;
            3'd3:    op = OP_IMM;
            3'd4:    op = OP_JUMP;
            3'd5:    op = OP_STORE;
            3'd6:    op = OP_BRANCH;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

    // rd source for single-cycle classes; loads take the memory path in WB instead.
    function automatic RDSourceSelectLines_t exec_select(input OpClass_t op);
        RDSourceSelectLines_t sel;
        case (op)
            OP_ALU:  sel = SEL_ALU;
            OP_IMM:  sel = SEL_IMM;
            OP_JUMP: sel = SEL_BRALU;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic writes_rd(input OpClass_t op);
        return (op == OP_ALU) || (op == OP_IMM) || (op == OP_JUMP);
    endfunction

endpackage

// File: rtl/writeback_sequencer_load_timeout_counter.sv
// rtl/writeback_sequencer_load_timeout_counter.sv - cycle counter bounding time spent waiting for a load
module load_timeout_counter #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TIMEOUT_WIDTH = $clog2(MEM_TIMEOUT + 1);

    logic [TIMEOUT_WIDTH-1:0] count;

    assign expired = (count == TIMEOUT_WIDTH'(MEM_TIMEOUT - 1));

    // Count wait cycles; hold at the expiry value so the counter can never wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/writeback_sequencer.sv
// rtl/writeback_sequencer.sv - sequences instruction writeback into the register file
import JZJCoreFTypes::*;

module writeback_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] op_class,
    input  logic [4:0] rd_index_in,
    output logic       mem_req,
    input  logic       mem_resp_valid,
    output logic [3:0] rd_source_select,
    output logic       rd_write_enable,
    output logic [4:0] rd_index_out,
    output logic       pc_advance,
    output logic       fault,
    input  logic       fault_clear
);

    StateWB_t             state;
    OpClass_t             op_q;
    logic [4:0]           rd_q;
    logic                 abandon_q;
    logic                 fault_q;
    logic                 expired;
    logic                 timeout_hit;
    RDSourceSelectLines_t sel;
    logic                 we;
    logic                 mr;
    logic                 pca;

    // A response arriving on the expiry cycle still wins over the timeout.
    assign timeout_hit = (state == LOAD_WAIT) && !mem_resp_valid && expired;

    load_timeout_counter #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == IDLE),
        .enable (state == LOAD_WAIT),
        .expired(expired)
    );

    // Writeback FSM: latch op/rd on accept, wait on loads, record abandons and faults.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= OP_NONE;
            rd_q      <= 5'd0;
            abandon_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            abandon_q <= timeout_hit;
            if (timeout_hit) begin
                fault_q <= 1'b1;
            end else if (fault_clear) begin
                fault_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_q  <= decode_op(op_class);
                        rd_q  <= rd_index_in;
                        state <= (decode_op(op_class) == OP_LOAD) ? LOAD_WAIT : EXEC;
                    end
                end
                EXEC: begin
                    state <= IDLE;
                end
                LOAD_WAIT: begin
                    if (mem_resp_valid) begin
                        state <= WB;
                    end else if (expired) begin
                        state <= IDLE;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore output decode from registered state and latched op/rd only.
    always_comb begin
        sel = SEL_NONE;
        we  = 1'b0;
        mr  = 1'b0;
        pca = abandon_q;
        case (state)
            EXEC: begin
                sel = exec_select(op_q);
                we  = writes_rd(op_q) && (rd_q != 5'd0);
                pca = 1'b1;
            end
            LOAD_WAIT: begin
                mr = 1'b1;
            end
            WB: begin
                sel = SEL_MEMORY;
                we  = (rd_q != 5'd0);
                pca = 1'b1;
            end
            default: begin
                sel = SEL_NONE;
            end
        endcase
    end

    assign instr_ready      = (state == IDLE);
    assign rd_source_select = sel;
    assign rd_write_enable  = we;
    assign mem_req          = mr;
    assign pc_advance       = pca;
    assign rd_index_out     = rd_q;
    assign fault            = fault_q;

endmodule

// File: tb/tb_writeback_sequencer.sv
// tb/tb_writeback_sequencer.sv - table-driven self-checking bench for writeback_sequencer
module tb_writeback_sequencer;

    localparam logic [2:0] K_NONE = 3'd0, K_ALU = 3'd1, K_LOAD = 3'd2, K_IMM = 3'd3;
    localparam logic [2:0] K_JUMP = 3'd4, K_STORE = 3'd5, K_BRANCH = 3'd6, K_BAD = 3'd7;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] op_class = 3'd0;
    logic [4:0] rd_index_in = 5'd0;
    logic       mem_req;
    logic       mem_resp_valid = 1'b0;
    logic [3:0] rd_source_select;
    logic       rd_write_enable;
    logic [4:0] rd_index_out;
    logic       pc_advance;
    logic       fault;
    logic       fault_clear = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       valid;
        logic [2:0] op;
        logic [4:0] rd;
        logic       resp;
        logic       clr;
        logic       ready;
        logic [3:0] sel;
        logic       we;
        logic [4:0] rdo;
        logic       mr;
        logic       pca;
        logic       flt;
    } vec_t;

    vec_t tbl[$];

    writeback_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .op_class        (op_class),
        .rd_index_in     (rd_index_in),
        .mem_req         (mem_req),
        .mem_resp_valid  (mem_resp_valid),
        .rd_source_select(rd_source_select),
        .rd_write_enable (rd_write_enable),
        .rd_index_out    (rd_index_out),
        .pc_advance      (pc_advance),
        .fault           (fault),
        .fault_clear     (fault_clear)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic add(input logic v, input logic [2:0] op, input logic [4:0] rd, input logic resp,
                       input logic clr, input logic rdy, input logic [3:0] sel, input logic we,
                       input logic [4:0] rdo, input logic mr, input logic pca, input logic flt);
        vec_t e;
        e.valid = v; e.op = op; e.rd = rd; e.resp = resp; e.clr = clr;
        e.ready = rdy; e.sel = sel; e.we = we; e.rdo = rdo; e.mr = mr; e.pca = pca; e.flt = flt;
        tbl.push_back(e);
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic [3:0] sel, input logic we,
                           input logic [4:0] rdo, input logic mr, input logic pca, input logic flt);
        chk({tag, " instr_ready"}, int'(instr_ready), int'(rdy));
        chk({tag, " rd_source_select"}, int'(rd_source_select), int'(sel));
        chk({tag, " rd_write_enable"}, int'(rd_write_enable), int'(we));
        chk({tag, " rd_index_out"}, int'(rd_index_out), int'(rdo));
        chk({tag, " mem_req"}, int'(mem_req), int'(mr));
        chk({tag, " pc_advance"}, int'(pc_advance), int'(pca));
        chk({tag, " fault"}, int'(fault), int'(flt));
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] rd,
                         input logic resp, input logic clr);
        instr_valid = v; op_class = op; rd_index_in = rd; mem_resp_valid = resp; fault_clear = clr;
    endtask

    initial begin
        // ALU rd=5, IMM rd=0, JUMP rd=31 with an ignored valid during EXEC
        add(0, K_NONE, 0, 0, 0,   1, 4'h0, 0, 0, 0, 0, 0);
        add(1, K_ALU, 5, 0, 0,    1, 4'h0, 0, 0, 0, 0, 0);
        add(0, K_NONE, 0, 0, 0,   0, 4'h4, 1, 5, 0, 1, 0);
        add(0, K_NONE, 0, 0, 0,   1, 4'h0, 0, 5, 0, 0, 0);
        add(1, K_IMM, 0, 0, 0,    1, 4'h0, 0, 5, 0, 0, 0);
        add(0, K_NONE, 0, 0, 0,   0, 4'h2, 0, 0, 0, 1, 0);
        add(1, K_JUMP, 31, 0, 0,  1, 4'h0, 0, 0, 0, 0, 0);
        add(1, K_ALU, 7, 0, 0,    0, 4'h1, 1, 31, 0, 1, 0);
        add(0, K_NONE, 0, 0, 0,   1, 4'h0, 0, 31, 0, 0, 0);
        // load rd=10, response on the 4th wait cycle (same cycle as expiry), valid held
        add(1, K_LOAD, 10, 0, 0,  1, 4'h0, 0, 31, 0, 0, 0);
        add(1, K_LOAD, 10, 0, 0,  0, 4'h0, 0, 10, 1, 0, 0);
        add(1, K_LOAD, 10, 0, 0,  0, 4'h0, 0, 10, 1, 0, 0);
        add(1, K_LOAD, 10, 0, 0,  0, 4'h0, 0, 10, 1, 0, 0);
        add(1, K_LOAD, 10, 1, 0,  0, 4'h0, 0, 10, 1, 0, 0);
        add(1, K_LOAD, 10, 1, 0,  0, 4'h8, 1, 10, 0, 1, 0);
        add(0, K_NONE, 0, 1, 0,   1, 4'h0, 0, 10, 0, 0, 0);
        // load rd=3 times out; second load times out with fault_clear in the expiry cycle
        add(1, K_LOAD, 3, 0, 0,   1, 4'h0, 0, 10, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, K_NONE, 0, 0, 0, 0, 4'h0, 0, 3, 1, 0, 0);
        add(1, K_LOAD, 0, 0, 0,   1, 4'h0, 0, 3, 0, 1, 1);
        for (int i = 0; i < 3; i++) add(0, K_NONE, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 1);
        add(0, K_NONE, 0, 0, 1,   0, 4'h0, 0, 0, 1, 0, 1);
        add(0, K_NONE, 0, 0, 0,   1, 4'h0, 0, 0, 0, 1, 1);
        add(0, K_NONE, 0, 0, 1,   1, 4'h0, 0, 0, 0, 0, 1);
        // store, branch, illegal op, ALU to x0
        add(1, K_STORE, 9, 0, 0,  1, 4'h0, 0, 0, 0, 0, 0);
        add(0, K_NONE, 0, 0, 0,   0, 4'h0, 0, 9, 0, 1, 0);
        add(1, K_BRANCH, 12, 0, 0, 1, 4'h0, 0, 9, 0, 0, 0);
        add(0, K_NONE, 0, 0, 0,   0, 4'h0, 0, 12, 0, 1, 0);
        add(1, K_BAD, 4, 0, 0,    1, 4'h0, 0, 12, 0, 0, 0);
        add(0, K_NONE, 0, 0, 0,   0, 4'h0, 0, 4, 0, 1, 0);
        add(1, K_ALU, 0, 0, 0,    1, 4'h0, 0, 4, 0, 0, 0);
        add(0, K_NONE, 0, 0, 0,   0, 4'h4, 0, 0, 0, 1, 0);
        // load to x0 with immediate response (N=0)
        add(1, K_LOAD, 0, 0, 0,   1, 4'h0, 0, 0, 0, 0, 0);
        add(0, K_NONE, 0, 1, 0,   0, 4'h0, 0, 0, 1, 0, 0);
        add(0, K_NONE, 0, 0, 0,   0, 4'h8, 0, 0, 0, 1, 0);
        add(0, K_NONE, 0, 0, 0,   1, 4'h0, 0, 0, 0, 0, 0);

        // reset state
        #2;
        chk_all("reset", 1, 4'h0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].op, tbl[i].rd, tbl[i].resp, tbl[i].clr);
            @(negedge clock);
            chk_all($sformatf("row%0d", i), tbl[i].ready, tbl[i].sel, tbl[i].we,
                    tbl[i].rdo, tbl[i].mr, tbl[i].pca, tbl[i].flt);
            @(posedge clock); #1;
        end

        // reset asserted mid LOAD_WAIT
        drive(1, K_LOAD, 6, 0, 0);
        @(posedge clock); #1;
        drive(0, K_NONE, 0, 0, 0);
        @(posedge clock); #1;
        chk("pre-reset mem_req", int'(mem_req), 1);
        #2 reset = 1'b1;
        #1 chk_all("async_reset", 1, 4'h0, 0, 0, 0, 0, 0);
        mem_resp_valid = 1'b1;
        @(posedge clock); #1;
        chk_all("held_reset", 1, 4'h0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        drive(1, K_ALU, 2, 0, 0);
        @(negedge clock);
        chk("post-reset ready", int'(instr_ready), 1);
        @(posedge clock); #1;
        drive(0, K_NONE, 0, 0, 0);
        @(negedge clock);
        chk_all("post-reset exec", 0, 4'h4, 1, 2, 0, 1, 0);
        @(posedge clock); #1;

        // random op stream: select-line invariants every cycle
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom % 2), 3'($urandom % 8), 5'($urandom),
                  1'(($urandom % 4) == 0), 1'(($urandom % 8) == 0));
            @(negedge clock);
            chk("rand sel onehot0", int'($countones(rd_source_select) <= 1), 1);
            chk("rand we needs one sel",
                int'(!rd_write_enable || ($countones(rd_source_select) == 1)), 1);
            chk("rand sel only in exec/wb", int'((rd_source_select != 4'h0) && instr_ready), 0);
            @(posedge clock); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/writeback_sequencer.md
Name: writeback_sequencer

Overview:
Multi-cycle controller that sequences each instruction's writeback into the register file.
- Accepts one decoded instruction per handshake.
- Waits for the memory response on loads.
- Drives the one-hot rd source-select lines that pick memory/ALU/immediate/branch-ALU data onto rd.
- Asserts the register-file write enable and the PC-advance strobe.
- Sits between the decoder and the rd source mux / register file.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in LOAD_WAIT before the load is abandoned; legal range 2..255.
TIMEOUT_WIDTH, $clog2(MEM_TIMEOUT+1), width of the wait counter; derived, never overridden.

Ports:
clock  input  1  single clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
instr_valid  input  1  decoder presents an instruction
instr_ready  output  1  sequencer accepts an instruction this cycle
op_class  input  3  OpClass_t: OP_NONE, OP_ALU, OP_LOAD, OP_IMM (lui/auipc), OP_JUMP (jal/jalr), OP_STORE, OP_BRANCH
rd_index_in  input  5  destination register of the presented instruction
mem_req  output  1  load request held to the memory unit
mem_resp_valid  input  1  memory data valid this cycle
rd_source_select  output  4  RDSourceSelectLines_t {memory, alu, immediateFormer, branchALU}; one-hot or all-zero
rd_write_enable  output  1  register-file write strobe
rd_index_out  output  5  latched destination register
pc_advance  output  1  one-cycle strobe: instruction retired or abandoned
fault  output  1  sticky: a load timed out
fault_clear  input  1  clears fault

Behaviour:
- States (StateWB_t): IDLE, EXEC, LOAD_WAIT, WB.
- All outputs are Moore-decoded from registered state plus latched op/rd. No input-to-output combinational path except instr_ready = (state == IDLE).
- Reset values: state IDLE; op latch OP_NONE; rd latch 0; counter 0; fault 0.
- Outputs during and after reset: rd_source_select 0; rd_write_enable 0; mem_req 0; pc_advance 0; rd_index_out 0; instr_ready 1.
- IDLE:
  - On instr_valid, latch op_class and rd_index_in.
  - OP_LOAD goes to LOAD_WAIT with the counter cleared. Every other class goes to EXEC.
  - Without instr_valid, stay in IDLE.
- EXEC (exactly 1 cycle, then IDLE):
  - rd_source_select: OP_ALU→alu, OP_IMM→immediateFormer, OP_JUMP→branchALU, other classes→0.
  - rd_write_enable = 1 only when the class writes rd (ALU/IMM/JUMP) and the latched rd ≠ 0.
  - pc_advance = 1.
- LOAD_WAIT:
  - mem_req = 1; all select lines 0; counter increments each cycle.
  - mem_resp_valid goes to WB.
  - If the counter reaches MEM_TIMEOUT−1 without a response: set fault, pulse pc_advance, go to IDLE, no write.
  - If mem_resp_valid arrives in the same cycle the counter reaches MEM_TIMEOUT−1, the response wins: go to WB, no fault.
- WB (exactly 1 cycle, then IDLE):
  - rd_source_select = memory.
  - rd_write_enable = (rd ≠ 0).
  - pc_advance = 1.
- Latency, valid handshake to retirement:
  - Non-load: 2 cycles (accept, then EXEC).
  - Load with a response N cycles after entering LOAD_WAIT (N ≥ 0): N+3 cycles.
- The select lines are never multi-hot. Select lines are never asserted outside EXEC/WB. rd_write_enable is only ever asserted together with exactly one select line.
- Ignored inputs:
  - instr_valid outside IDLE (instr_ready is 0).
  - mem_resp_valid outside LOAD_WAIT.
  - An illegal op_class encoding is treated as OP_NONE.
- fault:
  - Set dominates fault_clear in the same cycle.
  - fault does not block further instructions.
- Reset mid-operation: the in-flight instruction is discarded, with no write and no pc_advance.

Decomposition:
- Shared package JZJCoreFTypes:
  - OpClass_t and StateWB_t enums.
  - The existing RDSourceSelectLines_t is reused unchanged.
- One sub-module, load_timeout_counter:
  - Inputs: clear, enable.
  - Output: expired.
  - Same clock and async reset as the parent.

Test Plan:
1. Reset asserted mid-LOAD_WAIT, then released → all outputs 0 immediately, instr_ready=1, no pc_advance, next instruction accepted normally.
2. OP_ALU, rd=5, instr_valid for 1 cycle → next cycle rd_source_select=alu only, rd_write_enable=1, rd_index_out=5, pc_advance=1; following cycle back in IDLE.
3. OP_IMM with rd=0 → EXEC cycle has immediateFormer select, rd_write_enable=0, pc_advance=1.
4. OP_LOAD rd=10, mem_resp_valid 3 cycles after LOAD_WAIT entry → mem_req high 4 cycles, then WB with memory select, write to x10, total 6 cycles; instr_valid held throughout is not re-accepted until IDLE.
5. OP_LOAD with no response, MEM_TIMEOUT=4 → fault rises after 4 LOAD_WAIT cycles with pc_advance pulse and no write; fault_clear in the same cycle as a second timeout leaves fault=1.
6. OP_STORE and OP_BRANCH → pc_advance only; select lines 0 and no write enable in every cycle. Random op stream: assert the one-hot/zero select invariant each cycle.
